lfsr_gen: RTL and testbench

//  Parametrised LFSR pseudo-random generator; successor to the fixed 4-bit LFSR.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_next.sv | 24 ++
 rtl/lfsr_gen.sv | 108 ++++++++++
 tb/tb_lfsr_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and parameter checks for the parametrised LFSR generator.
package lfsr_pkg;

    localparam int unsigned MODE_FIB  = 0;
    localparam int unsigned MODE_GAL  = 1;
    localparam int unsigned WIDTH_MIN = 3;
    localparam int unsigned WIDTH_MAX = 32;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR next-state and serial-output logic for Fibonacci or Galois form.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned     WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(16'hB400),
    parameter int unsigned     MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] state_i,
    output logic [WIDTH-1:0] next_o,
    output logic             serial_o
);

    if (MODE == MODE_GAL) begin : g_galois
        assign next_o   = (state_i >> 1) ^ (state_i[0] ? TAPS : '0);
        assign serial_o = state_i[0];
    end else begin : g_fibonacci
        logic fb;
        assign fb       = ^(state_i & TAPS);
        assign next_o   = {state_i[WIDTH-2:0], fb};
        assign serial_o = state_i[WIDTH-1];
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR pattern generator with seed load, zero-state recovery,
// sequence-wrap detection and period measurement.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      MODE  = MODE_FIB
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    if (!width_ok(WIDTH)) begin : g_width_err
        $error("lfsr_gen: WIDTH must be in 3..32");
    end

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] q_next;
    logic             serial;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .state_i  (q_q),
        .next_o   (q_next),
        .serial_o (serial)
    );

    always_comb begin
        q_d      = q_q;
        start_d  = start_q;
        count_d  = count_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            // A zero seed would lock the register up; substitute the safe seed.
            if (seed_in == '0) begin
                q_d      = SEED;
                start_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                q_d     = seed_in;
                start_d = seed_in;
            end
            count_d = '0;
        end else if (en) begin
            if (q_q == '0) begin
                q_d      = SEED;
                count_d  = '0;
                lockup_d = 1'b1;
            end else begin
                q_d = q_next;
                if (q_next == start_q) begin
                    wrap_d   = 1'b1;
                    period_d = count_q + One;
                    count_d  = '0;
                end else begin
                    count_d = count_q + One;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_q      <= SEED;
            start_q  <= SEED;
            count_q  <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            start_q  <= start_d;
            count_q  <= count_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign q       = q_q;
    assign bit_out = serial;
    assign wrap    = wrap_q;
    assign period  = period_q;
    assign lockup  = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen (WIDTH=4, TAPS=4'hC, Fibonacci, SEED=1).
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [3:0] seed_in = 4'h0;
    logic [3:0] q;
    logic       bit_out;
    logic       wrap;
    logic [3:0] period;
    logic       lockup;

    int checks = 0;
    int errors = 0;

    // Reference model state, plain integers.
    int m_q, m_start, m_cnt, m_per;
    bit m_wrap, m_lock;

    lfsr_gen #(
        .WIDTH (4),
        .TAPS  (4'hC),
        .SEED  (4'h1),
        .MODE  (0)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .en      (en),
        .load    (load),
        .seed_in (seed_in),
        .q       (q),
        .bit_out (bit_out),
        .wrap    (wrap),
        .period  (period),
        .lockup  (lockup)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Fibonacci successor: shift left, new LSB is parity of the tapped bits (3 and 2).
    function automatic int fib_next(input int s);
        int fb;
        fb = $countones(s & 12) % 2;
        return ((s * 2) % 16) + fb;
    endfunction

    task automatic model_update(input bit c, input bit e, input bit l, input int s);
        int nxt;
        if (c) begin
            m_q = 1; m_start = 1; m_cnt = 0; m_per = 0; m_wrap = 0; m_lock = 0;
        end else begin
            m_wrap = 0;
            m_lock = 0;
            if (l) begin
                if (s == 0) begin
                    m_q = 1; m_start = 1; m_lock = 1;
                end else begin
                    m_q = s; m_start = s;
                end
                m_cnt = 0;
            end else if (e) begin
                if (m_q == 0) begin
                    m_q = 1; m_cnt = 0; m_lock = 1;
                end else begin
                    nxt = fib_next(m_q);
                    m_q = nxt;
                    if (nxt == m_start) begin
                        m_wrap = 1;
                        m_per  = (m_cnt + 1) % 16;
                        m_cnt  = 0;
                    end else begin
                        m_cnt = (m_cnt + 1) % 16;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit c, input bit e, input bit l, input logic [3:0] s);
        clr = c; en = e; load = l; seed_in = s;
        @(posedge clk);
        model_update(c, e, l, int'(s));
        #1;
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        chk("model_lockup", 32'(lockup), 32'(m_lock));
        chk("model_period", 32'(period), 32'(m_per));
        chk("model_bit_out", 32'(bit_out), 32'((m_q / 8) % 2));
    endtask

    typedef struct {
        bit         c;
        bit         e;
        bit         l;
        logic [3:0] s;
        logic [3:0] exp_q;
        bit         exp_wrap;
        bit         exp_lock;
    } vec_t;

    vec_t tbl[13];

    initial begin
        // Reset sequence and first steps, then zero-seed load recovery.
        tbl[0]  = '{1, 0, 0, 4'h0, 4'h1, 0, 0};
        tbl[1]  = '{1, 0, 0, 4'h0, 4'h1, 0, 0};
        tbl[2]  = '{1, 0, 0, 4'h0, 4'h1, 0, 0};
        tbl[3]  = '{0, 1, 0, 4'h0, 4'h2, 0, 0};
        tbl[4]  = '{0, 1, 0, 4'h0, 4'h4, 0, 0};
        tbl[5]  = '{0, 1, 0, 4'h0, 4'h9, 0, 0};
        tbl[6]  = '{0, 1, 0, 4'h0, 4'h3, 0, 0};
        tbl[7]  = '{0, 1, 0, 4'h0, 4'h6, 0, 0};
        tbl[8]  = '{0, 1, 0, 4'h0, 4'hD, 0, 0};
        tbl[9]  = '{0, 0, 1, 4'h0, 4'h1, 0, 1};
        tbl[10] = '{0, 1, 0, 4'h0, 4'h2, 0, 0};
        tbl[11] = '{0, 0, 0, 4'h0, 4'h2, 0, 0};
        tbl[12] = '{0, 0, 1, 4'h7, 4'h7, 0, 0};

        #2;
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].c, tbl[i].e, tbl[i].l, tbl[i].s);
            chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].exp_q));
            chk($sformatf("tbl%0d_wrap", i), 32'(wrap), 32'(tbl[i].exp_wrap));
            chk($sformatf("tbl%0d_lockup", i), 32'(lockup), 32'(tbl[i].exp_lock));
        end

        // Full cycle from reset: wrap once on step 15, period 15.
        step(1, 0, 0, 4'h0);
        chk("clr_period", 32'(period), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, 0, 4'h0);
            if (i < 15) chk("wrap_early", 32'(wrap), 32'd0);
        end
        chk("wrap_q", 32'(q), 32'h1);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        chk("wrap_period", 32'(period), 32'd15);
        step(0, 0, 0, 4'h0);
        chk("wrap_single", 32'(wrap), 32'd0);
        chk("period_hold", 32'(period), 32'd15);

        // Cycle from loaded seed 1010.
        step(0, 0, 1, 4'hA);
        chk("load_q", 32'(q), 32'hA);
        for (int i = 1; i <= 15; i++) begin
            step(0, 1, 0, 4'h0);
            if (i < 15) chk("seed_wrap_early", 32'(wrap), 32'd0);
        end
        chk("seed_wrap_q", 32'(q), 32'hA);
        chk("seed_wrap_pulse", 32'(wrap), 32'd1);
        chk("seed_wrap_period", 32'(period), 32'd15);

        // clr mid-sequence at step 7 with en high.
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'h0);
        step(1, 1, 0, 4'h0);
        chk("clr7_q", 32'(q), 32'h1);
        chk("clr7_period", 32'(period), 32'd0);
        chk("clr7_wrap", 32'(wrap), 32'd0);

        // clr on the step that would have wrapped.
        for (int i = 0; i < 14; i++) step(0, 1, 0, 4'h0);
        step(1, 1, 0, 4'h0);
        chk("clr_pending_wrap", 32'(wrap), 32'd0);
        chk("clr_pending_period", 32'(period), 32'd0);

        // Hold with en low, then load beats en.
        for (int i = 0; i < 15; i++) step(0, 1, 0, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 4'h0);
            chk("hold_q", 32'(q), 32'h9);
            chk("hold_period", 32'(period), 32'd15);
            chk("hold_wrap", 32'(wrap), 32'd0);
        end
        step(0, 1, 1, 4'h5);
        chk("load_wins_q", 32'(q), 32'h5);
        step(0, 1, 0, 4'h0);
        chk("after_load_step_q", 32'(q), 32'hB);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit rc, re, rl;
            logic [3:0] rs;
            rc = ($urandom_range(0, 99) < 2);
            rl = ($urandom_range(0, 99) < 8);
            re = ($urandom_range(0, 99) < 80);
            rs = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(rc, re, rl, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
